// File: rtl/niosiie_onchip_memory_dp.sv
// niosiie_onchip_memory_dp
// True-dual-port on-chip RAM with two Avalon-MM slaves (s1, s2) sharing one
// array. Fixed-latency pipelined reads with readdatavalid, waitrequest
// back-pressure from the clock enable, and s1-wins arbitration when both
// ports write the same word in the same cycle.
module niosiie_onchip_memory_dp #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 4,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clken,
  input  logic                      reset_req,

  input  logic                      s1_chipselect,
  input  logic                      s1_read,
  input  logic                      s1_write,
  input  logic [ADDR_WIDTH-1:0]     s1_address,
  input  logic [DATA_WIDTH/8-1:0]   s1_byteenable,
  input  logic [DATA_WIDTH-1:0]     s1_writedata,
  output logic                      s1_waitrequest,
  output logic [DATA_WIDTH-1:0]     s1_readdata,
  output logic                      s1_readdatavalid,

  input  logic                      s2_chipselect,
  input  logic                      s2_read,
  input  logic                      s2_write,
  input  logic [ADDR_WIDTH-1:0]     s2_address,
  input  logic [DATA_WIDTH/8-1:0]   s2_byteenable,
  input  logic [DATA_WIDTH-1:0]     s2_writedata,
  output logic                      s2_waitrequest,
  output logic [DATA_WIDTH-1:0]     s2_readdata,
  output logic                      s2_readdatavalid
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 2 ** ADDR_WIDTH;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_read_latency
    $error("niosiie_onchip_memory_dp: READ_LATENCY must be 1 or 2");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Both ports are folded into index 0 (s1) and 1 (s2) so the read path is
  // written once.
  logic                  cs     [2];
  logic                  rd     [2];
  logic                  wr     [2];
  logic [ADDR_WIDTH-1:0] addr   [2];
  logic [BE_WIDTH-1:0]   be     [2];
  logic [DATA_WIDTH-1:0] wdata  [2];
  logic                  wait_r [2];
  logic                  acc_wr [2];
  logic                  acc_rd [2];
  logic [DATA_WIDTH-1:0] rd_word[2];

  logic                  clocken;
  logic                  wr_collide;

  assign cs[0]    = s1_chipselect;
  assign rd[0]    = s1_read;
  assign wr[0]    = s1_write;
  assign addr[0]  = s1_address;
  assign be[0]    = s1_byteenable;
  assign wdata[0] = s1_writedata;

  assign cs[1]    = s2_chipselect;
  assign rd[1]    = s2_read;
  assign wr[1]    = s2_write;
  assign addr[1]  = s2_address;
  assign be[1]    = s2_byteenable;
  assign wdata[1] = s2_writedata;

  assign clocken = clken & ~reset_req;

  // Same-word double write: s1 goes first, s2 is held off one cycle so its
  // data lands last and is the final content.
  assign wr_collide = cs[0] & wr[0] & cs[1] & wr[1] & (addr[0] == addr[1]);

  assign wait_r[0] = reset | ~clocken;
  assign wait_r[1] = reset | ~clocken | wr_collide;

  assign s1_waitrequest = wait_r[0];
  assign s2_waitrequest = wait_r[1];

  // Accept qualification; a combined read+write performs only the write.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      acc_wr[p] = cs[p] & wr[p] & ~wait_r[p];
      acc_rd[p] = cs[p] & rd[p] & ~wr[p] & ~wait_r[p];
    end
  end

  // Array update, byte-lane masked; s2 assigned last so it would win a tie.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (acc_wr[p]) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
          if (be[p][b]) begin
            mem[addr[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
          end
        end
      end
    end
  end

  // Read word as seen at the accept edge: a same-cycle write from the other
  // port to the same word is forwarded lane by lane so the read sees new data.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_word[p] = mem[addr[p]];
      if (acc_wr[1-p] && (addr[1-p] == addr[p])) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
          if (be[1-p][b]) begin
            rd_word[p][b*8 +: 8] = wdata[1-p][b*8 +: 8];
          end
        end
      end
    end
  end

  // Read pipeline: stage 0 captures at the accept edge, the output register
  // is READ_LATENCY edges later. Everything freezes while clocken is low.
  logic [READ_LATENCY-1:0] vld_q   [2];
  logic [DATA_WIDTH-1:0]   dat_q   [2][READ_LATENCY];
  logic                    rvalid_q[2];
  logic [DATA_WIDTH-1:0]   rdata_q [2];
  logic [DATA_WIDTH-1:0]   rdata_d [2];

  // Output data only moves when a valid word reaches the last stage, so
  // readdata holds between valids.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata_d[p] = rdata_q[p];
      if (vld_q[p][READ_LATENCY-1]) begin
        rdata_d[p] = dat_q[p][READ_LATENCY-1];
      end
    end
  end

  // Pipeline advance; async reset drops anything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        vld_q[p]    <= '0;
        rvalid_q[p] <= 1'b0;
        rdata_q[p]  <= '0;
        for (int k = 0; k < READ_LATENCY; k++) begin
          dat_q[p][k] <= '0;
        end
      end
    end else if (clocken) begin
      for (int p = 0; p < 2; p++) begin
        vld_q[p][0] <= acc_rd[p];
        if (acc_rd[p]) begin
          dat_q[p][0] <= rd_word[p];
        end
        for (int k = 1; k < READ_LATENCY; k++) begin
          vld_q[p][k] <= vld_q[p][k-1];
          dat_q[p][k] <= dat_q[p][k-1];
        end
        rvalid_q[p] <= vld_q[p][READ_LATENCY-1];
        rdata_q[p]  <= rdata_d[p];
      end
    end
  end

  // A pending valid is hidden while stalled and shows once clocken returns.
  assign s1_readdatavalid = rvalid_q[0] & clocken;
  assign s2_readdatavalid = rvalid_q[1] & clocken;
  assign s1_readdata      = rdata_q[0];
  assign s2_readdata      = rdata_q[1];

endmodule

// File: tb/tb_niosiie_onchip_memory_dp.sv
// Directed bench: instance u_a (READ_LATENCY=1) for the port/collision cases,
// instance u_b (READ_LATENCY=2) for the pipelined stall case.
module tb_niosiie_onchip_memory_dp;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int BW = 4;

  logic clk;
  logic rst;

  logic          a_clken, a_rreq;
  logic          a1_cs, a1_rd, a1_wr, a2_cs, a2_rd, a2_wr;
  logic [AW-1:0] a1_addr, a2_addr;
  logic [BW-1:0] a1_be, a2_be;
  logic [DW-1:0] a1_wd, a2_wd;
  logic          a1_wait, a2_wait, a1_rvalid, a2_rvalid;
  logic [DW-1:0] a1_rdata, a2_rdata;

  logic          b_clken, b_rreq;
  logic          b1_cs, b1_rd, b1_wr, b2_cs, b2_rd, b2_wr;
  logic [AW-1:0] b1_addr, b2_addr;
  logic [BW-1:0] b1_be, b2_be;
  logic [DW-1:0] b1_wd, b2_wd;
  logic          b1_wait, b2_wait, b1_rvalid, b2_rvalid;
  logic [DW-1:0] b1_rdata, b2_rdata;

  int errors = 0;
  int checks = 0;

  niosiie_onchip_memory_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_a (
    .clk(clk), .reset(rst), .clken(a_clken), .reset_req(a_rreq),
    .s1_chipselect(a1_cs), .s1_read(a1_rd), .s1_write(a1_wr), .s1_address(a1_addr),
    .s1_byteenable(a1_be), .s1_writedata(a1_wd), .s1_waitrequest(a1_wait),
    .s1_readdata(a1_rdata), .s1_readdatavalid(a1_rvalid),
    .s2_chipselect(a2_cs), .s2_read(a2_rd), .s2_write(a2_wr), .s2_address(a2_addr),
    .s2_byteenable(a2_be), .s2_writedata(a2_wd), .s2_waitrequest(a2_wait),
    .s2_readdata(a2_rdata), .s2_readdatavalid(a2_rvalid)
  );

  niosiie_onchip_memory_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) u_b (
    .clk(clk), .reset(rst), .clken(b_clken), .reset_req(b_rreq),
    .s1_chipselect(b1_cs), .s1_read(b1_rd), .s1_write(b1_wr), .s1_address(b1_addr),
    .s1_byteenable(b1_be), .s1_writedata(b1_wd), .s1_waitrequest(b1_wait),
    .s1_readdata(b1_rdata), .s1_readdatavalid(b1_rvalid),
    .s2_chipselect(b2_cs), .s2_read(b2_rd), .s2_write(b2_wr), .s2_address(b2_addr),
    .s2_byteenable(b2_be), .s2_writedata(b2_wd), .s2_waitrequest(b2_wait),
    .s2_readdata(b2_rdata), .s2_readdatavalid(b2_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a1_cs = 0; a1_rd = 0; a1_wr = 0; a1_addr = '0; a1_be = '0; a1_wd = '0;
    a2_cs = 0; a2_rd = 0; a2_wr = 0; a2_addr = '0; a2_be = '0; a2_wd = '0;
  endtask

  task automatic idle_b();
    b1_cs = 0; b1_rd = 0; b1_wr = 0; b1_addr = '0; b1_be = '0; b1_wd = '0;
    b2_cs = 0; b2_rd = 0; b2_wr = 0; b2_addr = '0; b2_be = '0; b2_wd = '0;
  endtask

  task automatic test_reset();
    rst = 1; a_clken = 1; a_rreq = 0; b_clken = 1; b_rreq = 0;
    idle_a(); idle_b();
    tick(); tick();
    checks++; if (a1_wait !== 1'b1) begin errors++; $display("FAIL rst_s1_wait got=%0b exp=1", a1_wait); end
    checks++; if (a2_wait !== 1'b1) begin errors++; $display("FAIL rst_s2_wait got=%0b exp=1", a2_wait); end
    checks++; if (a1_rvalid !== 1'b0 || a2_rvalid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b%0b exp=00", a1_rvalid, a2_rvalid); end
    checks++; if (a1_rdata !== 32'h0 || a2_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h/%h exp=0", a1_rdata, a2_rdata); end
    rst = 0;
    #1;
    checks++; if (a1_wait !== 1'b0) begin errors++; $display("FAIL rst_release_wait got=%0b exp=0", a1_wait); end
    tick();
  endtask

  task automatic test_cross_port_rw();
    a1_cs = 1; a1_wr = 1; a1_addr = 3; a1_be = 4'hF; a1_wd = 32'hDEADBEEF;
    tick();
    idle_a(); a2_cs = 1; a2_rd = 1; a2_addr = 3;
    tick();
    idle_a();
    checks++; if (a2_rvalid !== 1'b0) begin errors++; $display("FAIL t1_early_valid got=%0b exp=0", a2_rvalid); end
    tick();
    checks++; if (a2_rvalid !== 1'b1) begin errors++; $display("FAIL t1_valid got=%0b exp=1", a2_rvalid); end
    checks++; if (a2_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_rdata got=%h exp=DEADBEEF", a2_rdata); end
    tick();
    checks++; if (a2_rvalid !== 1'b0) begin errors++; $display("FAIL t1_valid_pulse got=%0b exp=0", a2_rvalid); end
    checks++; if (a2_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_rdata_hold got=%h exp=DEADBEEF", a2_rdata); end
  endtask

  task automatic test_byteenable();
    a2_cs = 1; a2_wr = 1; a2_addr = 3; a2_be = 4'b0101; a2_wd = 32'h11223344;
    tick();
    idle_a(); a1_cs = 1; a1_rd = 1; a1_addr = 3;
    tick();
    idle_a();
    tick();
    checks++; if (a1_rvalid !== 1'b1) begin errors++; $display("FAIL t2_valid got=%0b exp=1", a1_rvalid); end
    checks++; if (a1_rdata !== 32'hDE22BE44) begin errors++; $display("FAIL t2_rdata got=%h exp=DE22BE44", a1_rdata); end
  endtask

  task automatic test_write_collision();
    a1_cs = 1; a1_wr = 1; a1_addr = 5; a1_be = 4'hF; a1_wd = 32'hAAAA0000;
    a2_cs = 1; a2_wr = 1; a2_addr = 5; a2_be = 4'hF; a2_wd = 32'h0000BBBB;
    #1;
    checks++; if (a2_wait !== 1'b1) begin errors++; $display("FAIL t3_s2_wait got=%0b exp=1", a2_wait); end
    checks++; if (a1_wait !== 1'b0) begin errors++; $display("FAIL t3_s1_wait got=%0b exp=0", a1_wait); end
    tick();
    a1_cs = 0; a1_wr = 0;
    #1;
    checks++; if (a2_wait !== 1'b0) begin errors++; $display("FAIL t3_s2_retry_wait got=%0b exp=0", a2_wait); end
    tick();
    idle_a(); a1_cs = 1; a1_rd = 1; a1_addr = 5;
    tick();
    idle_a();
    tick();
    checks++; if (a1_rvalid !== 1'b1 || a1_rdata !== 32'h0000BBBB) begin errors++; $display("FAIL t3_final got=%0b/%h exp=1/0000BBBB", a1_rvalid, a1_rdata); end
  endtask

  task automatic test_read_during_write();
    a1_cs = 1; a1_wr = 1; a1_addr = 7; a1_be = 4'hF; a1_wd = 32'h12345678;
    a2_cs = 1; a2_rd = 1; a2_addr = 7;
    #1;
    checks++; if (a2_wait !== 1'b0) begin errors++; $display("FAIL t4_s2_wait got=%0b exp=0", a2_wait); end
    tick();
    idle_a();
    tick();
    checks++; if (a2_rvalid !== 1'b1) begin errors++; $display("FAIL t4_valid got=%0b exp=1", a2_rvalid); end
    checks++; if (a2_rdata !== 32'h12345678) begin errors++; $display("FAIL t4_rdata got=%h exp=12345678", a2_rdata); end
  endtask

  task automatic test_rw_and_be0();
    a1_cs = 1; a1_rd = 1; a1_wr = 1; a1_addr = 9; a1_be = 4'hF; a1_wd = 32'h00000055;
    tick();
    idle_a();
    tick();
    checks++; if (a1_rvalid !== 1'b0) begin errors++; $display("FAIL rw_no_valid got=%0b exp=0", a1_rvalid); end
    a1_cs = 1; a1_wr = 1; a1_addr = 9; a1_be = 4'h0; a1_wd = 32'hFFFFFFFF;
    tick();
    idle_a(); a1_cs = 1; a1_rd = 1; a1_addr = 9;
    tick();
    idle_a();
    tick();
    checks++; if (a1_rvalid !== 1'b1 || a1_rdata !== 32'h00000055) begin errors++; $display("FAIL be0_rdata got=%0b/%h exp=1/00000055", a1_rvalid, a1_rdata); end
  endtask

  task automatic test_clken();
    a1_cs = 1; a1_wr = 1; a1_addr = 10; a1_be = 4'hF; a1_wd = 32'h00000010;
    tick();
    a_clken = 0; a1_wd = 32'h00000077;
    #1;
    checks++; if (a1_wait !== 1'b1) begin errors++; $display("FAIL ce_wait got=%0b exp=1", a1_wait); end
    tick();
    a_clken = 1; idle_a(); a1_cs = 1; a1_rd = 1; a1_addr = 10;
    tick();
    idle_a();
    tick();
    // valid register now set; stall before it is consumed
    a_clken = 0;
    #1;
    checks++; if (a1_rvalid !== 1'b0) begin errors++; $display("FAIL ce_mask got=%0b exp=0", a1_rvalid); end
    tick();
    checks++; if (a1_rvalid !== 1'b0) begin errors++; $display("FAIL ce_mask2 got=%0b exp=0", a1_rvalid); end
    a_clken = 1;
    #1;
    checks++; if (a1_rvalid !== 1'b1 || a1_rdata !== 32'h00000010) begin errors++; $display("FAIL ce_resume got=%0b/%h exp=1/00000010", a1_rvalid, a1_rdata); end
    tick();
    checks++; if (a1_rvalid !== 1'b0) begin errors++; $display("FAIL ce_once got=%0b exp=0", a1_rvalid); end
  endtask

  task automatic test_back_to_back_stall();
    logic [DW-1:0] exp_q [4];
    for (int i = 0; i < 4; i++) begin
      exp_q[i] = 32'hB000_0000 + 32'(i);
      b1_cs = 1; b1_wr = 1; b1_addr = AW'(i); b1_be = 4'hF; b1_wd = exp_q[i];
      tick();
    end
    idle_b();
    b1_cs = 1; b1_rd = 1; b1_addr = 0;
    tick();
    b1_addr = 1;
    tick();
    b_rreq = 1; b1_addr = 2;
    #1;
    checks++; if (b1_wait !== 1'b1) begin errors++; $display("FAIL t5_wait1 got=%0b exp=1", b1_wait); end
    tick();
    checks++; if (b1_wait !== 1'b1 || b1_rvalid !== 1'b0) begin errors++; $display("FAIL t5_wait2 got=%0b/%0b exp=1/0", b1_wait, b1_rvalid); end
    tick();
    checks++; if (b1_rvalid !== 1'b0) begin errors++; $display("FAIL t5_gap got=%0b exp=0", b1_rvalid); end
    b_rreq = 0;
    tick();
    checks++; if (b1_rvalid !== 1'b1 || b1_rdata !== exp_q[0]) begin errors++; $display("FAIL t5_v0 got=%0b/%h exp=1/%h", b1_rvalid, b1_rdata, exp_q[0]); end
    b1_addr = 3;
    tick();
    checks++; if (b1_rvalid !== 1'b1 || b1_rdata !== exp_q[1]) begin errors++; $display("FAIL t5_v1 got=%0b/%h exp=1/%h", b1_rvalid, b1_rdata, exp_q[1]); end
    idle_b();
    tick();
    checks++; if (b1_rvalid !== 1'b1 || b1_rdata !== exp_q[2]) begin errors++; $display("FAIL t5_v2 got=%0b/%h exp=1/%h", b1_rvalid, b1_rdata, exp_q[2]); end
    tick();
    checks++; if (b1_rvalid !== 1'b1 || b1_rdata !== exp_q[3]) begin errors++; $display("FAIL t5_v3 got=%0b/%h exp=1/%h", b1_rvalid, b1_rdata, exp_q[3]); end
    tick();
    checks++; if (b1_rvalid !== 1'b0) begin errors++; $display("FAIL t5_no_extra got=%0b exp=0", b1_rvalid); end
  endtask

  task automatic test_reset_drop();
    a1_cs = 1; a1_rd = 1; a1_addr = 3;
    tick();
    idle_a();
    rst = 1;
    #1;
    checks++; if (a1_rvalid !== 1'b0 || a1_rdata !== 32'h0) begin errors++; $display("FAIL t6_cleared got=%0b/%h exp=0/0", a1_rvalid, a1_rdata); end
    checks++; if (a1_wait !== 1'b1) begin errors++; $display("FAIL t6_wait got=%0b exp=1", a1_wait); end
    tick();
    tick();
    checks++; if (a1_rvalid !== 1'b0) begin errors++; $display("FAIL t6_dropped got=%0b exp=0", a1_rvalid); end
    rst = 0;
    tick();
    a1_cs = 1; a1_rd = 1; a1_addr = 3;
    tick();
    idle_a();
    checks++; if (a1_rvalid !== 1'b0) begin errors++; $display("FAIL t6_stale_valid got=%0b exp=0", a1_rvalid); end
    tick();
    checks++; if (a1_rvalid !== 1'b1 || a1_rdata !== 32'hDE22BE44) begin errors++; $display("FAIL t6_retained got=%0b/%h exp=1/DE22BE44", a1_rvalid, a1_rdata); end
  endtask

  initial begin
    test_reset();
    test_cross_port_rw();
    test_byteenable();
    test_write_collision();
    test_read_during_write();
    test_rw_and_be0();
    test_clken();
    test_back_to_back_stall();
    test_reset_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
